// File: rtl/game_pkg.sv
// Shared definitions for the memory-game stages (display/start and check).
package game_pkg;

    localparam int unsigned DISPLAY_CYCLE = 10;
    localparam int unsigned DATA_W        = 10;
    localparam int unsigned ADDR_W        = 4;
    localparam int unsigned SCORE_W       = 4;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WAIT_KEY = 2'd1,
        COMPARE  = 2'd2,
        DONE     = 2'd3
    } game_state_e;

endpackage

// File: rtl/key_edge.sv
// One-cycle rising-edge detector for a debounced key level.
module key_edge (
    input  logic clk,
    input  logic reset,
    input  logic key,
    output logic rise_c
);

    logic key_q;

    // Previous key level; tracked in every state so a held key never re-fires.
    always_ff @(posedge clk) begin
        if (reset) begin
            key_q <= 1'b0;
        end else begin
            key_q <= key;
        end
    end

    assign rise_c = key & ~key_q;

endmodule

// File: rtl/game_check.sv
// Replays the stored pattern sequence against player entries and scores the round.
module game_check #(
    parameter int unsigned DISPLAY_CYCLE = game_pkg::DISPLAY_CYCLE,
    parameter int unsigned DATA_W        = game_pkg::DATA_W,
    parameter int unsigned ADDR_W        = game_pkg::ADDR_W,
    parameter int unsigned SCORE_W       = game_pkg::SCORE_W
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start_check,
    input  logic               confirm_key,
    input  logic [DATA_W-1:0]  sw,
    input  logic [DATA_W-1:0]  rd_data,
    output logic [ADDR_W-1:0]  rn,
    output logic [DATA_W-1:0]  led,
    output logic [SCORE_W-1:0] score,
    output logic               busy,
    output logic               done,
    output logic               pass
);

    import game_pkg::*;

    localparam logic [ADDR_W-1:0]  LAST_IDX   = ADDR_W'(DISPLAY_CYCLE - 1);
    localparam logic [SCORE_W-1:0] FULL_SCORE = SCORE_W'(DISPLAY_CYCLE);

    game_state_e        state_q;
    game_state_e        state_d;
    logic [ADDR_W-1:0]  rn_d;
    logic [DATA_W-1:0]  led_d;
    logic [SCORE_W-1:0] score_d;
    logic               busy_d;
    logic               done_d;
    logic               pass_d;
    logic [DATA_W-1:0]  guess_q;
    logic [DATA_W-1:0]  guess_d;
    logic [DATA_W-1:0]  ref_q;
    logic [DATA_W-1:0]  ref_d;
    logic               key_rise_c;
    logic               match_c;
    logic [SCORE_W-1:0] score_inc_c;

    key_edge u_key_edge (
        .clk    (clk),
        .reset  (reset),
        .key    (confirm_key),
        .rise_c (key_rise_c)
    );

    // Exact full-width match of the captured guess against the stored pattern.
    assign match_c     = (guess_q == ref_q);
    assign score_inc_c = (match_c && (score < FULL_SCORE)) ? score + SCORE_W'(1) : score;

    // State and registered outputs; reset clears the round including the partial score.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            rn      <= '0;
            led     <= '0;
            score   <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            pass    <= 1'b0;
            guess_q <= '0;
            ref_q   <= '0;
        end else begin
            state_q <= state_d;
            rn      <= rn_d;
            led     <= led_d;
            score   <= score_d;
            busy    <= busy_d;
            done    <= done_d;
            pass    <= pass_d;
            guess_q <= guess_d;
            ref_q   <= ref_d;
        end
    end

    // Next state and next output values.
    always_comb begin
        state_d = state_q;
        rn_d    = rn;
        led_d   = led;
        score_d = score;
        busy_d  = busy;
        done_d  = done;
        pass_d  = pass;
        guess_d = guess_q;
        ref_d   = ref_q;

        case (state_q)
            IDLE: begin
                rn_d   = '0;
                led_d  = '0;
                busy_d = 1'b0;
                done_d = 1'b0;
                if (start_check) begin
                    state_d = WAIT_KEY;
                    score_d = '0;
                    busy_d  = 1'b1;
                    led_d   = sw;
                end
            end

            WAIT_KEY: begin
                busy_d = 1'b1;
                done_d = 1'b0;
                led_d  = sw;
                if (key_rise_c) begin
                    state_d = COMPARE;
                    guess_d = sw;
                    ref_d   = rd_data;
                end
            end

            COMPARE: begin
                score_d = score_inc_c;
                if (rn == LAST_IDX) begin
                    state_d = DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                    pass_d  = (score_inc_c == FULL_SCORE);
                    led_d   = {DATA_W{pass_d}};
                end else begin
                    state_d = WAIT_KEY;
                    rn_d    = rn + ADDR_W'(1);
                    led_d   = sw;
                end
            end

            DONE: begin
                busy_d = 1'b0;
                done_d = 1'b1;
                led_d  = {DATA_W{pass}};
                if (start_check) begin
                    state_d = WAIT_KEY;
                    rn_d    = '0;
                    score_d = '0;
                    busy_d  = 1'b1;
                    done_d  = 1'b0;
                    led_d   = sw;
                end
            end

            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Score can never pass the number of entries in a round.
    a_score_bound: assert property (@(posedge clk) disable iff (reset) score <= FULL_SCORE);

endmodule

// File: tb/tb_game_check.sv
// Scoreboard bench for game_check: randomized rounds against a per-entry score model.
module tb_game_check;

    localparam int N  = 10;
    localparam int DW = 10;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          start_check = 1'b0;
    logic          confirm_key = 1'b0;
    logic [DW-1:0] sw = '0;
    logic [DW-1:0] rd_data;
    logic [3:0]    rn;
    logic [DW-1:0] led;
    logic [3:0]    score;
    logic          busy;
    logic          done;
    logic          pass;

    logic [DW-1:0] mem [16];

    typedef struct {
        bit          last;
        int unsigned rn;
        int unsigned score;
        bit          pass;
        logic [9:0]  led;
    } exp_t;

    exp_t exp_q [$];

    int errors = 0;
    int checks = 0;
    int exp_score = 0;
    int exp_idx = 0;

    logic [3:0] rn_prev = '0;
    logic       busy_prev = 1'b0;
    logic       done_prev = 1'b0;

    game_check dut (
        .clk         (clk),
        .reset       (reset),
        .start_check (start_check),
        .confirm_key (confirm_key),
        .sw          (sw),
        .rd_data     (rd_data),
        .rn          (rn),
        .led         (led),
        .score       (score),
        .busy        (busy),
        .done        (done),
        .pass        (pass)
    );

    assign rd_data = mem[rn];

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: one event per completed entry (rn advances, or done rises on the last one).
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (!reset && busy_prev && ((rn != rn_prev) || (done && !done_prev))) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_compare: rn=%0d score=%0d with nothing expected at %0t",
                         rn, score, $time);
            end else begin
                e = exp_q.pop_front();
                chk("evt_last", 32'(done), 32'(e.last));
                chk("evt_rn", 32'(rn), 32'(e.rn));
                chk("evt_score", 32'(score), 32'(e.score));
                if (e.last) begin
                    chk("final_pass", 32'(pass), 32'(e.pass));
                    chk("final_led", 32'(led), 32'(e.led));
                    chk("final_busy", 32'(busy), 32'd0);
                end
            end
        end
        rn_prev   = rn;
        busy_prev = busy;
        done_prev = done;
    end

    task automatic start_round(input bit check_restart);
        @(negedge clk);
        start_check = 1'b1;
        @(negedge clk);
        start_check = 1'b0;
        exp_score = 0;
        exp_idx   = 0;
        if (check_restart) begin
            chk("restart_done", 32'(done), 32'd0);
            chk("restart_score", 32'(score), 32'd0);
            chk("restart_rn", 32'(rn), 32'd0);
            chk("restart_busy", 32'(busy), 32'd1);
        end
    endtask

    // Model one entry: score counts exact matches; push the expected outcome, then press.
    task automatic entry(input logic [DW-1:0] v, input int hold, input int gap);
        exp_t e;
        if (v == mem[exp_idx]) exp_score++;
        e.last  = (exp_idx == N - 1);
        e.rn    = e.last ? N - 1 : exp_idx + 1;
        e.score = exp_score;
        e.pass  = (exp_score == N);
        e.led   = e.pass ? 10'h3FF : 10'h000;
        exp_q.push_back(e);
        exp_idx++;
        @(negedge clk);
        sw = v;
        confirm_key = 1'b1;
        repeat (hold) @(negedge clk);
        confirm_key = 1'b0;
        repeat (2 + gap) @(negedge clk);
    endtask

    task automatic wait_done();
        int n = 0;
        while (!done && n < 30) begin
            @(negedge clk);
            n++;
        end
        chk("done_seen", 32'(done), 32'd1);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 16; i++) mem[i] = 10'(i * 3 + 1);

        // Reset values
        repeat (3) @(negedge clk);
        chk("rst_rn", 32'(rn), 32'd0);
        chk("rst_led", 32'(led), 32'd0);
        chk("rst_score", 32'(score), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_pass", 32'(pass), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Perfect round
        start_round(1'b0);
        for (int i = 0; i < N; i++) entry(mem[i], 3, 0);
        wait_done();

        // Partial round from DONE, with an ignored start pulse mid-round
        start_round(1'b1);
        for (int i = 0; i < N; i++) begin
            entry((i == 2 || i == 7) ? 10'd0 : mem[i], 3, 0);
            if (i == 4) begin
                @(negedge clk);
                start_check = 1'b1;
                @(negedge clk);
                start_check = 1'b0;
                @(negedge clk);
                chk("mid_start_rn", 32'(rn), 32'd5);
                chk("mid_start_score", 32'(score), 32'(exp_score));
                chk("mid_start_busy", 32'(busy), 32'd1);
            end
        end
        wait_done();

        // Key held across start, held entry, and all-ones pattern on the last entry
        mem[9] = 10'h3FF;
        @(negedge clk);
        confirm_key = 1'b1;
        repeat (2) @(negedge clk);
        start_round(1'b1);
        repeat (5) @(negedge clk);
        chk("held_start_rn", 32'(rn), 32'd0);
        confirm_key = 1'b0;
        @(negedge clk);
        entry(mem[0], 20, 0);
        chk("held_rn", 32'(rn), 32'd1);
        for (int i = 1; i < N; i++) entry(mem[i], 2, 1);
        wait_done();
        repeat (3) @(negedge clk);
        chk("last_rn_hold", 32'(rn), 32'd9);
        chk("last_done_hold", 32'(done), 32'd1);

        // Mid-round reset after four correct entries
        start_round(1'b1);
        for (int i = 0; i < 4; i++) entry(mem[i], 3, 0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        chk("mrst_rn", 32'(rn), 32'd0);
        chk("mrst_score", 32'(score), 32'd0);
        chk("mrst_busy", 32'(busy), 32'd0);
        chk("mrst_led", 32'(led), 32'd0);
        chk("mrst_done", 32'(done), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        start_round(1'b0);
        chk("mrst_restart_rn", 32'(rn), 32'd0);
        for (int i = 0; i < N; i++) entry(mem[i], 1, 0);
        wait_done();

        // Random rounds
        for (int r = 0; r < 4; r++) begin
            for (int i = 0; i < N; i++) mem[i] = 10'($urandom);
            start_round(1'b1);
            for (int i = 0; i < N; i++) begin
                logic [DW-1:0] v;
                v = ($urandom_range(0, 1) == 1) ? mem[i] : 10'($urandom);
                entry(v, int'($urandom_range(1, 4)), int'($urandom_range(0, 3)));
            end
            wait_done();
        end

        repeat (3) @(negedge clk);
        chk("queue_empty", 32'(exp_q.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/game_check.md
Name: game_check

Overview:
- Downstream stage of the memory-game display/start stage. That stage writes DISPLAY_CYCLE random 10-bit patterns into the game register file.
- This block replays the sequence against player input. The player sets switches and presses a confirm key once per entry.
- The block reads the stored pattern, compares the two, and accumulates a score.
- At the end it raises done and a pass/fail verdict for the score/display logic.

Parameters:
- DISPLAY_CYCLE, 10, number of entries stored per round and checked per round.
- DATA_W, 10, width of one stored pattern, the switch input and the LED bus.
- ADDR_W, 4, register-file address width; must satisfy 2**ADDR_W >= DISPLAY_CYCLE.
- SCORE_W, 4, score counter width; must hold DISPLAY_CYCLE.

Ports:
- clk  input  1  system clock; all logic on the rising edge.
- reset  input  1  synchronous, active-high reset.
- start_check  input  1  one-cycle pulse from the display stage when the round's writes are complete.
- confirm_key  input  1  debounced level, active-high; player "enter" button.
- sw  input  DATA_W  player's guess from the switches.
- rd_data  input  DATA_W  register-file read data; combinational from rn.
- rn  output  ADDR_W  register-file read address.
- led  output  DATA_W  echoes sw while checking; all-ones on pass, zero otherwise.
- score  output  SCORE_W  number of correct entries so far.
- busy  output  1  high in WAIT_KEY and COMPARE.
- done  output  1  high in DONE.
- pass  output  1  valid when done; 1 iff score == DISPLAY_CYCLE.

Behaviour:
- Reset: state IDLE; rn=0, led=0, score=0, busy=0, done=0, pass=0; key-edge register=0. Reset wins over every other input in the same cycle.
- Key edge detection:
  - key_q registers confirm_key each cycle.
  - key_rise = confirm_key & ~key_q.
  - A held key produces exactly one rise.
  - key_q is also updated in IDLE, so a key already held at start produces no rise.
- IDLE:
  - Outputs at reset values except score/pass, which hold their last values.
  - start_check=1 -> WAIT_KEY with rn=0 and score=0.
- WAIT_KEY:
  - busy=1, led=sw, rn=current index.
  - key_rise=1 -> COMPARE, capturing sw into guess_q and rd_data into ref_q in that same cycle.
  - start_check is ignored in this state.
- COMPARE (exactly one cycle):
  - If guess_q == ref_q, score increments by 1.
  - If rn == DISPLAY_CYCLE-1 -> DONE.
  - Otherwise rn increments by 1 and the next state is WAIT_KEY.
  - A key_rise during COMPARE is dropped.
- DONE:
  - busy=0, done=1.
  - pass is registered on the DONE-entry cycle from the final score.
  - led = all-ones if pass, else 0.
  - score and pass hold.
  - start_check=1 -> WAIT_KEY with rn=0 and score=0, starting a new round; done deasserts the next cycle.
- Latency: 1 cycle from key_rise to the COMPARE state, and 2 cycles from key_rise to score update and rn advance.
- Width rules:
  - rn never exceeds DISPLAY_CYCLE-1; no wrap-around.
  - score saturates at DISPLAY_CYCLE. It cannot exceed it structurally; the assertion checks this.
- Mid-round reset: immediate return to IDLE with all outputs cleared; the partial score is lost.
- Comparison is exact full-width equality on DATA_W bits.

Decomposition:
- Shared package game_pkg holds:
  - state enum (IDLE, WAIT_KEY, COMPARE, DONE);
  - DISPLAY_CYCLE, DATA_W, ADDR_W defaults, used by both this stage and the display stage.
- One natural sub-module: key_edge, the 1-bit rising-edge detector. It is reusable for start_key in the display stage.
- The FSM and datapath stay in game_check.

Test Plan:
- Perfect round: preload regfile[i]=i*3+1. Pulse start_check, then for each i set sw=i*3+1 and press the key for 3 cycles. Expected: score=10, done=1, pass=1, led=10'h3FF; rn steps 0..9, one step per press.
- Partial round: same preload, sw wrong on entries 2 and 7 (sw=0). Expected: score=8, done=1, pass=0, led=0.
- Held key: hold confirm_key high for 20 cycles on entry 0. Expected: exactly one COMPARE, rn=1, score incremented by at most 1. A key already high when start_check arrives produces no compare until released and pressed again.
- Mid-round reset: assert reset after 4 correct entries. Expected on the next cycle: state IDLE, score=0, rn=0, busy=0, led=0; a new start_check restarts from index 0.
- Restart from DONE: after a failed round, pulse start_check. Expected: done=0 and score=0 on the next cycle, rn=0, busy=1. A start_check pulsed mid-round (in WAIT_KEY) has no effect on rn or score.
- Boundary compare: regfile[9]=10'h3FF and sw=10'h3FF on the last entry. Expected: the match is counted, DONE is entered, and rn does not advance past 9.
